pattern_det_ctrl: RTL and testbench
===================================

Name: pattern_det_ctrl

Overview:
Programmable serial pattern-detection controller for the team's sequence-detector datapath (the 1010-style Moore detectors).
- Loads a pattern, its length and an overlap mode through a config port.
- Arms on start, consumes a qualified serial bit stream, and pulses a registered (Moore) match.
- Counts matches and stops with done when a programmable target count is reached.
- Replaces per-pattern hard-coded detector FSMs at the system level.

Parameters:
PAT_W, 4, maximum pattern length in bits.
LEN_W, 3, width of cfg_len (must hold PAT_W).
CNT_W, 8, width of match counter and target.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
cfg_we  input  1  config write strobe, honoured only in IDLE
cfg_pattern  input  PAT_W  pattern; first received bit = bit [len-1]
cfg_len  input  LEN_W  pattern length, 1..PAT_W
cfg_ovp  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  input  CNT_W  match count that ends the run; 0 = run until abort
start  input  1  arm request
abort  input  1  stop request
in_valid  input  1  qualifies in
in  input  1  serial data bit
match  output  1  one-cycle pulse, registered
match_cnt  output  CNT_W  matches counted in the current run
busy  output  1  high in RUN
done  output  1  one-cycle pulse when target is reached

Behaviour:
- Reset (rst=0, async): state=IDLE; history, bit count and config registers cleared; match=0, match_cnt=0, busy=0, done=0.
- States:
  - IDLE: cfg_we latches pattern/len/ovp/target.
  - IDLE->RUN on start when latched len != 0. This clears history, bit count and match_cnt.
  - RUN->IDLE on abort.
  - RUN->DONE when match_cnt reaches target (target != 0).
  - DONE->IDLE unconditionally after 1 cycle.
- Length rules: len > PAT_W is clamped to PAT_W at latch. len=0 makes start ignored.
- RUN datapath, on each edge with in_valid=1:
  - hist <= {hist[PAT_W-2:0], in}; seen <= seen+1, saturating at PAT_W.
  - Hit when (seen+1) >= len and the new hist[len-1:0] equals pattern[len-1:0].
- Latency: match is high the cycle after the completing bit's edge. match_cnt updates on that same edge.
- Hit with ovp=0: seen cleared to 0, so later bits start a fresh pattern. Hit with ovp=1: seen is kept.
- Bits with in_valid=0 are ignored; they neither advance nor reset the history.
- match_cnt saturates at all-ones.
- Target reached: state goes to DONE on the same edge as the match. done=1 and busy=0 for one cycle. Bits in DONE/IDLE are ignored.
- match_cnt holds its value in IDLE until the next start.
- Conflicts:
  - start while in RUN/DONE is ignored.
  - cfg_we outside IDLE is ignored.
  - start and cfg_we together in IDLE: config latches, start uses the old config.
  - start and abort together in IDLE: abort wins, stay IDLE.
  - abort on the completing bit's edge: abort wins, no match, no count.
- Reset mid-run: all outputs drop immediately and the latched config is lost.

Optional Feature:
PAT_DET_MASK_EN
- Defined: adds port cfg_mask (input, PAT_W), latched with cfg_we. Positions with mask bit 1 are don't-care in the compare.
- Undefined: port absent; all len bits are compared.

Decomposition:
- Package pat_det_pkg: state encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10; default width constants.
- Sub-module pat_det_shreg: history shift register, seen counter and masked comparator; outputs the combinational hit.
- Top level keeps the FSM, config registers and counters.

Test Plan:
- Reset during RUN with a partial pattern -> match, busy, done, match_cnt all 0 immediately; IDLE after release.
- pattern=4'b1010, len=4, ovp=0, target=0; stream 1,0,1,0,1,0 -> single match pulse after bit 4; match_cnt=1.
- Same stream with ovp=1 -> match pulses after bits 4 and 6; match_cnt=2.
- ovp=1, target=2; stream 1,0,1,0,1,0,1,0 -> done pulse on the cycle after bit 6; busy low from then on; bits 7-8 ignored; match_cnt stays 2.
- ovp=0; stream 1,0,0,0,1,0,1,0 with in_valid low on two cycles between bits 2 and 3 -> no match until bit 8, then match_cnt=1.
- abort asserted on the edge of bit 4 of 1,0,1,0 -> no match; state IDLE; match_cnt=0. A cfg_we in RUN with a new pattern has no effect.

Source files
------------

// File: rtl/pat_det_pkg.sv
// Shared constants for the programmable pattern-detection controller:
// FSM state encoding and default widths.
package pat_det_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int LEN_W_DEF = 3;
    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/pat_det_shreg.sv
// History shift register, saturating seen-bit counter and masked comparator.
// hit is combinational: it reports that the bit being shifted in on this
// edge completes the pattern. Requires PAT_W >= 2.
module pat_det_shreg #(
    parameter int PAT_W = 4,
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             din,
    input  logic             ovp,
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    output logic             hit
);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_nxt;
    logic [LEN_W-1:0] seen;
    logic [LEN_W:0]   seen_inc;
    logic             cmp_ok;

    // Compare the would-be history against the pattern over the low len bits,
    // skipping masked positions; the seen check stops a match built from
    // stale history left before a fresh start.
    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], din};
        seen_inc = {1'b0, seen} + (LEN_W+1)'(1);
        cmp_ok   = 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
            if ((i < int'(len)) && !mask[i] && (hist_nxt[i] != pattern[i])) begin
                cmp_ok = 1'b0;
            end
        end
        hit = shift && (seen_inc >= {1'b0, len}) && cmp_ok;
    end

    // History and seen counter advance only on qualified bits; a
    // non-overlapping hit restarts the seen count so the next pattern is fresh.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            seen <= '0;
        end else if (clear) begin
            hist <= '0;
            seen <= '0;
        end else if (shift) begin
            hist <= hist_nxt;
            if (hit && !ovp) begin
                seen <= '0;
            end else if (seen != LEN_W'(PAT_W)) begin
                seen <= seen + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_det_ctrl.sv
// Programmable serial pattern-detection controller.
// Holds the IDLE/RUN/DONE FSM, the latched configuration and the match
// counter; the bit history and compare live in pat_det_shreg.
// Optional build macro PAT_DET_MASK_EN adds cfg_mask (don't-care positions).
//
// Handshake: in is consumed on a rising edge only when in_valid=1 and the
// FSM is in RUN; there is no backpressure, every qualified bit is taken.
module pattern_det_ctrl
    import pat_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovp,
    input  logic [CNT_W-1:0] cfg_target,
`ifdef PAT_DET_MASK_EN
    input  logic [PAT_W-1:0] cfg_mask,
`endif
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       fsm_state
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovp_q;
    logic [CNT_W-1:0] tgt_q;
    logic [PAT_W-1:0] mask_q;
    logic [LEN_W-1:0] len_clamped;
    logic [CNT_W-1:0] cnt_inc;
    logic             cfg_take;
    logic             run_go;
    logic             shift;
    logic             hit;
    logic             tgt_hit;

    // Decode of config acceptance, arming, bit qualification and target.
    always_comb begin
        len_clamped = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
        cfg_take    = (state == ST_IDLE) && cfg_we;
        run_go      = (state == ST_IDLE) && start && !abort && (len_q != '0);
        shift       = (state == ST_RUN) && in_valid && !abort;
        cnt_inc     = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
        tgt_hit     = hit && (tgt_q != '0) && (cnt_inc == tgt_q);
    end

    // Configuration registers, writable only while IDLE. start in the same
    // cycle sees the previous values because run_go reads the registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= '0;
            len_q  <= '0;
            ovp_q  <= 1'b0;
            tgt_q  <= '0;
            mask_q <= '0;
        end else if (cfg_take) begin
            pat_q  <= cfg_pattern;
            len_q  <= len_clamped;
            ovp_q  <= cfg_ovp;
            tgt_q  <= cfg_target;
`ifdef PAT_DET_MASK_EN
            mask_q <= cfg_mask;
`else
            mask_q <= '0;
`endif
        end
    end

    // Next-state logic; abort takes priority over both arming and matching.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (run_go) state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (tgt_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered match pulse and saturating match counter; the counter
    // clears on arming and otherwise holds outside RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= hit;
            if (run_go) begin
                match_cnt <= '0;
            end else if (hit) begin
                match_cnt <= cnt_inc;
            end
        end
    end

    pat_det_shreg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .clear   (run_go),
        .shift   (shift),
        .din     (in),
        .ovp     (ovp_q),
        .len     (len_q),
        .pattern (pat_q),
        .mask    (mask_q),
        .hit     (hit)
    );

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Directed bench for pattern_det_ctrl: each driven bit pushes its expected
// {match, busy, done, match_cnt} to a queue that is popped after the edge.
module tb_pattern_det_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [3:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       cfg_ovp;
    logic [7:0] cfg_target;
`ifdef PAT_DET_MASK_EN
    logic [3:0] cfg_mask;
`endif
    logic       start;
    logic       abort;
    logic       in_valid;
    logic       in;
    logic       match;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;
    logic [1:0] fsm_state;

    logic [10:0] exp_q[$];
    int n_cmp;
    int n_err;

    pattern_det_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_ovp     (cfg_ovp),
        .cfg_target  (cfg_target),
`ifdef PAT_DET_MASK_EN
        .cfg_mask    (cfg_mask),
`endif
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in          (in),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .fsm_state   (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stream input, then compare the DUT against the
    // expectation pushed for that cycle.
    task automatic step(input string tag, input logic v, input logic b, input logic a,
                        input logic em, input logic eb, input logic ed, input logic [7:0] ec);
        logic [10:0] e;
        in_valid = v;
        in       = b;
        abort    = a;
        exp_q.push_back({em, eb, ed, ec});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        e = exp_q.pop_front();
        chk({tag, ".match"}, 32'(match), 32'(e[10]));
        chk({tag, ".busy"},  32'(busy),  32'(e[9]));
        chk({tag, ".done"},  32'(done),  32'(e[8]));
        chk({tag, ".cnt"},   32'(match_cnt), 32'(e[7:0]));
    endtask

    task automatic cfg(input logic [3:0] p, input logic [2:0] l, input logic o, input logic [7:0] t);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_ovp     = o;
        cfg_target  = t;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic arm(input string tag);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".arm_busy"}, 32'(busy), 32'd1);
        chk({tag, ".arm_cnt"},  32'(match_cnt), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        cfg_we = 1'b0; cfg_pattern = 4'h0; cfg_len = 3'd0; cfg_ovp = 1'b0; cfg_target = 8'd0;
`ifdef PAT_DET_MASK_EN
        cfg_mask = 4'h0;
`endif
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.match", 32'(match), 32'd0);
        chk("rst.busy",  32'(busy),  32'd0);
        chk("rst.done",  32'(done),  32'd0);
        chk("rst.cnt",   32'(match_cnt), 32'd0);
        chk("rst.state", 32'(fsm_state), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Non-overlapping 1010: only one match in 101010.
        cfg(4'b1010, 3'd4, 1'b0, 8'd0);
        arm("s1");
        step("s1.b1", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s1.b2", 1, 0, 0, 0, 1, 0, 8'd0);
        step("s1.b3", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s1.b4", 1, 0, 0, 1, 1, 0, 8'd1);
        step("s1.b5", 1, 1, 0, 0, 1, 0, 8'd1);
        step("s1.b6", 1, 0, 0, 0, 1, 0, 8'd1);
        step("s1.abort", 0, 0, 1, 0, 0, 0, 8'd1);

        // Overlapping: matches after bits 4 and 6.
        cfg(4'b1010, 3'd4, 1'b1, 8'd0);
        arm("s2");
        step("s2.b1", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s2.b2", 1, 0, 0, 0, 1, 0, 8'd0);
        step("s2.b3", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s2.b4", 1, 0, 0, 1, 1, 0, 8'd1);
        step("s2.b5", 1, 1, 0, 0, 1, 0, 8'd1);
        step("s2.b6", 1, 0, 0, 1, 1, 0, 8'd2);
        step("s2.abort", 0, 0, 1, 0, 0, 0, 8'd2);

        // Target 2: done with the second match, later bits ignored.
        cfg(4'b1010, 3'd4, 1'b1, 8'd2);
        arm("s3");
        step("s3.b1", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s3.b2", 1, 0, 0, 0, 1, 0, 8'd0);
        step("s3.b3", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s3.b4", 1, 0, 0, 1, 1, 0, 8'd1);
        step("s3.b5", 1, 1, 0, 0, 1, 0, 8'd1);
        step("s3.b6", 1, 0, 0, 1, 0, 1, 8'd2);
        step("s3.b7", 1, 1, 0, 0, 0, 0, 8'd2);
        step("s3.b8", 1, 0, 0, 0, 0, 0, 8'd2);
        chk("s3.state", 32'(fsm_state), 32'd0);

        // len=7 clamps to 4; invalid cycles carry junk that must be ignored.
        cfg(4'b1010, 3'd7, 1'b0, 8'd0);
        arm("s4");
        step("s4.b1", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s4.b2", 1, 0, 0, 0, 1, 0, 8'd0);
        step("s4.iv1", 0, 1, 0, 0, 1, 0, 8'd0);
        step("s4.iv2", 0, 1, 0, 0, 1, 0, 8'd0);
        step("s4.b3", 1, 0, 0, 0, 1, 0, 8'd0);
        step("s4.b4", 1, 0, 0, 0, 1, 0, 8'd0);
        step("s4.b5", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s4.b6", 1, 0, 0, 0, 1, 0, 8'd0);
        step("s4.b7", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s4.b8", 1, 0, 0, 1, 1, 0, 8'd1);
        step("s4.abort", 0, 0, 1, 0, 0, 0, 8'd1);

        // Abort on the completing bit wins over the match.
        arm("s5");
        step("s5.b1", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s5.b2", 1, 0, 0, 0, 1, 0, 8'd0);
        step("s5.b3", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s5.b4", 1, 0, 1, 0, 0, 0, 8'd0);
        chk("s5.state", 32'(fsm_state), 32'd0);

        // Config write during RUN (pattern 0101) must not take effect.
        arm("s6");
        cfg_we = 1'b1; cfg_pattern = 4'b0101; cfg_len = 3'd4; cfg_ovp = 1'b0; cfg_target = 8'd0;
        step("s6.b1", 1, 1, 0, 0, 1, 0, 8'd0);
        cfg_we = 1'b0;
        step("s6.b2", 1, 0, 0, 0, 1, 0, 8'd0);
        step("s6.b3", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s6.b4", 1, 0, 0, 1, 1, 0, 8'd1);
        step("s6.b5", 1, 1, 0, 0, 1, 0, 8'd1);
        step("s6.abort", 0, 0, 1, 0, 0, 0, 8'd1);

        // start together with abort in IDLE stays IDLE.
        start = 1'b1;
        step("s7.start_abort", 0, 0, 1, 0, 0, 0, 8'd1);
        start = 1'b0;

        // Reset in the middle of a run drops every output at once.
        arm("s8");
        step("s8.b1", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s8.b2", 1, 0, 0, 0, 1, 0, 8'd0);
        step("s8.b3", 1, 1, 0, 0, 1, 0, 8'd0);
        step("s8.b4", 1, 0, 0, 1, 1, 0, 8'd1);
        in_valid = 1'b1; in = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("s8.rst_match", 32'(match), 32'd0);
        chk("s8.rst_busy",  32'(busy),  32'd0);
        chk("s8.rst_done",  32'(done),  32'd0);
        chk("s8.rst_cnt",   32'(match_cnt), 32'd0);
        chk("s8.rst_state", 32'(fsm_state), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        // Config was lost (len=0), so start is ignored.
        start = 1'b1;
        step("s8.start_len0", 0, 0, 0, 0, 0, 0, 8'd0);
        start = 1'b0;
        chk("s8.state", 32'(fsm_state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
